// File: rtl/pe_mac_pipe.sv
// pe_mac_pipe: two-stage pipelined signed MAC processing element for the torus systolic array.
// Weight-stationary operands add an incoming partial sum; output-stationary operands accumulate locally until drained.
module pe_mac_pipe #(
  parameter int OPERAND_WIDTH = 8,
  parameter int ACC_WIDTH     = 24,
  parameter bit SATURATE      = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     reset,
  input  logic                     mode_i,
  input  logic                     valid_i,
  input  logic [OPERAND_WIDTH-1:0] a_i,
  input  logic [OPERAND_WIDTH-1:0] b_i,
  input  logic                     w_load_i,
  input  logic [ACC_WIDTH-1:0]     psum_i,
  input  logic                     drain_i,
  input  logic                     clear_i,
  output logic [OPERAND_WIDTH-1:0] a_o,
  output logic [OPERAND_WIDTH-1:0] b_o,
  output logic                     valid_o,
  output logic                     w_load_o,
  output logic [ACC_WIDTH-1:0]     psum_o,
  output logic                     psum_valid_o,
  output logic                     ovf_o
);
  localparam int PW = 2 * OPERAND_WIDTH;
  localparam int SW = ACC_WIDTH + 1;

  if (ACC_WIDTH < PW) begin : g_width_check
    $error("pe_mac_pipe: ACC_WIDTH must be at least 2*OPERAND_WIDTH");
  end

  // The extra sum bit disagrees with the accumulator sign bit exactly when the true sum is out of range.
  function automatic logic out_of_range(input logic [SW-1:0] s);
    return s[SW-1] != s[SW-2];
  endfunction

  function automatic logic [ACC_WIDTH-1:0] fit(input logic [SW-1:0] s);
    logic [ACC_WIDTH-1:0] r;
    if (out_of_range(s) && SATURATE) begin
      r = s[SW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      r = s[ACC_WIDTH-1:0];
    end
    return r;
  endfunction

  logic [OPERAND_WIDTH-1:0] w;
  logic [OPERAND_WIDTH-1:0] mul_b;
  logic signed [PW-1:0]     a_ext;
  logic signed [PW-1:0]     b_ext;
  logic signed [PW-1:0]     product;
  logic [PW-1:0]            p1;
  logic [ACC_WIDTH-1:0]     ps1;
  logic                     v1;
  logic                     m1;
  logic [ACC_WIDTH-1:0]     acc;
  logic [SW-1:0]            p1_ext;
  logic [SW-1:0]            ws_sum;
  logic [SW-1:0]            acc_sum;
  logic [ACC_WIDTH-1:0]     acc_next;
  logic [ACC_WIDTH-1:0]     psum_next;
  logic                     psum_valid_next;
  logic                     ovf_event;
  logic                     ovf_next;

  // Stage 1 multiplies by the weight register that was in place before any load this cycle.
  assign mul_b   = mode_i ? b_i : w;
  assign a_ext   = {{OPERAND_WIDTH{a_i[OPERAND_WIDTH-1]}}, a_i};
  assign b_ext   = {{OPERAND_WIDTH{mul_b[OPERAND_WIDTH-1]}}, mul_b};
  assign product = a_ext * b_ext;

  assign p1_ext  = {{(SW-PW){p1[PW-1]}}, p1};
  assign ws_sum  = {ps1[ACC_WIDTH-1], ps1} + p1_ext;
  assign acc_sum = {acc[ACC_WIDTH-1], acc} + ((v1 && m1) ? p1_ext : {SW{1'b0}});

  // Stage 2: commit WS result or drain, update accumulator and sticky overflow
  always_comb begin
    psum_next       = psum_o;
    psum_valid_next = 1'b0;
    acc_next        = acc;
    ovf_event       = 1'b0;
    ovf_next        = ovf_o;
    if (v1 && !m1) begin
      psum_next       = fit(ws_sum);
      psum_valid_next = 1'b1;
      ovf_event       = out_of_range(ws_sum);
    end else if (drain_i) begin
      psum_next       = fit(acc_sum);
      psum_valid_next = 1'b1;
      ovf_event       = out_of_range(acc_sum);
    end else begin
      psum_next       = psum_o;
    end
    if (clear_i || drain_i) begin
      acc_next = {ACC_WIDTH{1'b0}};
    end else if (v1 && m1) begin
      acc_next  = fit(acc_sum);
      ovf_event = out_of_range(acc_sum);
    end else begin
      acc_next = acc;
    end
    ovf_next = clear_i ? 1'b0 : (ovf_o | ovf_event);
  end

  // Forwarding, weight register and both pipeline stages
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      a_o          <= {OPERAND_WIDTH{1'b0}};
      b_o          <= {OPERAND_WIDTH{1'b0}};
      valid_o      <= 1'b0;
      w_load_o     <= 1'b0;
      w            <= {OPERAND_WIDTH{1'b0}};
      p1           <= {PW{1'b0}};
      ps1          <= {ACC_WIDTH{1'b0}};
      v1           <= 1'b0;
      m1           <= 1'b0;
      acc          <= {ACC_WIDTH{1'b0}};
      psum_o       <= {ACC_WIDTH{1'b0}};
      psum_valid_o <= 1'b0;
      ovf_o        <= 1'b0;
    end else begin
      a_o          <= a_i;
      b_o          <= b_i;
      valid_o      <= valid_i;
      w_load_o     <= w_load_i;
      if (w_load_i) begin
        w <= b_i;
      end else begin
        w <= w;
      end
      p1           <= product;
      ps1          <= psum_i;
      v1           <= valid_i;
      m1           <= mode_i;
      acc          <= acc_next;
      psum_o       <= psum_next;
      psum_valid_o <= psum_valid_next;
      ovf_o        <= ovf_next;
    end
  end

endmodule

// File: doc/pe_mac_pipe.md
# pe_mac_pipe

Parametrised, two-stage pipelined signed MAC processing element for the torus systolic array. It supports two dataflows selected per operand: weight-stationary (WS), where partial sums flow through the PE, and output-stationary (OS), where the PE accumulates locally and drains on command. It adds configurable operand and accumulator widths, operand valid propagation, saturating or wrapping arithmetic, and a sticky overflow flag.

## Interface
- OPERAND_WIDTH, 8: signed bit width of A/B operands.
- ACC_WIDTH, 24: signed width of partial sum and accumulator; must be ≥ 2*OPERAND_WIDTH (elaboration error otherwise).
- SATURATE, 1: 1 = clamp sums to ACC_WIDTH signed range; 0 = two's-complement wrap.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- mode_i  in  1  0 = WS, 1 = OS; sampled with valid_i, carried down the pipeline.
- valid_i  in  1  a_i/b_i (and psum_i in WS) valid this cycle.
- a_i  in  OPERAND_WIDTH  signed activation.
- b_i  in  OPERAND_WIDTH  signed weight (WS load data) or OS multiplicand.
- w_load_i  in  1  WS: latch b_i into weight register w.
- psum_i  in  ACC_WIDTH  signed incoming partial sum (WS only).
- drain_i  in  1  OS: emit accumulator on psum_o and restart accumulation.
- clear_i  in  1  synchronous clear of accumulator and ovf_o.
- a_o, b_o  out  OPERAND_WIDTH  a_i/b_i registered 1 cycle.
- valid_o, w_load_o  out  1  valid_i/w_load_i registered 1 cycle.
- psum_o  out  ACC_WIDTH  result.
- psum_valid_o  out  1  psum_o valid this cycle (single-cycle pulse per result).
- ovf_o  out  1  sticky: any saturation/wrap event since reset or clear_i.

## Operation
- Reset: all outputs, w, acc, and pipeline registers are 0.
- Forwarding: a_o, b_o, valid_o, w_load_o are registered copies of their inputs every cycle, regardless of valid_i or mode.
- Weight register: on w_load_i, w <= b_i. Stage 1 in the same cycle uses the old w; the new w is used from the next cycle.
- Stage 1 (edge k): p1 <= a_i * (mode_i ? b_i : w), a full 2*OPERAND_WIDTH signed product. Also registers ps1 <= psum_i, v1 <= valid_i, m1 <= mode_i.
- Stage 2 (edge k+1): the sign-extended p1 is added at ACC_WIDTH+1 bits.
  - SATURATE=1: clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - SATURATE=0: drop the MSB.
  - Either way, ovf_o <= 1 if the exact sum is out of range, and only when that sum is committed.
- WS (v1 & !m1): psum_o <= sat(ps1 + p1); psum_valid_o <= 1. acc untouched.
- OS (v1 & m1): acc <= sat(acc + p1). No psum_valid_o.
- Drain (drain_i, evaluated in stage 2):
  - psum_o <= sat(acc + (v1&m1 ? p1 : 0)); psum_valid_o <= 1; acc <= 0.
  - Operands presented on the drain cycle enter stage 1 and begin the next accumulation.
- drain_i together with a WS result in stage 2: the WS result wins on psum_o; acc <= 0 with its value discarded. Illegal use; the bench flags it.
- clear_i: acc <= 0, ovf_o <= 0.
  - With drain_i in the same cycle, the drain result is still emitted and ovf_o ends at 0.
  - clear_i has priority over an overflow set in the same cycle.
- No valid in stage 2 and no drain: psum_o holds its value; psum_valid_o <= 0.
- Mode may change on any cycle: each operand completes in the mode it was issued with.

## Timing
- Forwarded outputs: 1-cycle latency.
- WS psum_o / psum_valid_o: 2 cycles after valid_i.
- OS: drain_i at edge k gives psum_o at edge k+1. The accumulator includes products whose valid_i was at edge k-1 or earlier.
- Throughput: 1 operand per cycle, no stalls, no backpressure.
- Reset asserted mid-operation: outputs go to 0 asynchronously; in-flight products are lost. The first valid after deassertion behaves as from power-up.

## Test plan
- Reset mid-accumulate (OS, acc=50, v1=1): assert reset between edges → all outputs 0 before the next edge; after release, a drain gives psum_o=0.
- WS: load w=-3; next cycle a_i=5, psum_i=100, valid_i=1 → a_o=5 at +1; psum_o=85 with psum_valid_o=1 at +2; w_load same-cycle case uses the old w.
- OS accumulate: (a,b)=(2,10),(3,-1),(4,5) on consecutive cycles, drain_i one cycle after the last → psum_o=37. Operand (1,7) issued on the drain cycle → next drain psum_o=7.
- Saturation (OW=8, AW=16), WS, psum_i=32767, a=127, w=127:
  - SATURATE=1 → psum_o=32767, ovf_o=1.
  - SATURATE=0 → psum_o=-16640, ovf_o=1.
- Signed extremes: a=-128, b=-128 (OS), drain → psum_o=16384, ovf_o=0.
- clear_i with drain_i in the same cycle, ovf_o=1, acc=9 → psum_o=9, psum_valid_o=1, ovf_o=0, next drain psum_o=0.
